// File: rtl/queue_cmd_front.sv
// Command front-end for the indexed queue: ADD/CANCEL/POP by ID.
// Sequenced IDLE->EXEC->CHECK->RESP so that at most one queue strobe fires per command.
module queue_cmd_front #(
    parameter int PAYLOAD_SIZE = 24,
    parameter int ID_WIDTH     = 8,
    parameter int FIFO_SIZE    = 1024,
    parameter int PTR_WIDTH    = $clog2(FIFO_SIZE),
    parameter int QDATA_SIZE   = PAYLOAD_SIZE + ID_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic [PAYLOAD_SIZE-1:0] cmd_payload,
    output logic                    q_push_flag,
    output logic [QDATA_SIZE-1:0]   q_push_data,
    output logic                    q_pop_flag,
    input  logic [QDATA_SIZE-1:0]   q_pop_data,
    output logic                    q_remove_flag,
    output logic [PTR_WIDTH-1:0]    q_remove_index,
    input  logic                    q_full,
    input  logic                    q_empty,
    input  logic                    q_error_reg,
    input  logic                    q_error_rem,
    input  logic                    q_error_time,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2:0]              rsp_status,
    output logic [ID_WIDTH-1:0]     rsp_id,
    output logic [PAYLOAD_SIZE-1:0] rsp_payload
);

    localparam int DEPTH = 2 ** ID_WIDTH;

    localparam logic [1:0] OP_ADD    = 2'd0;
    localparam logic [1:0] OP_CANCEL = 2'd1;
    localparam logic [1:0] OP_POP    = 2'd2;

    localparam logic [2:0] ST_OK    = 3'd0;
    localparam logic [2:0] ST_DUP   = 3'd1;
    localparam logic [2:0] ST_NF    = 3'd2;
    localparam logic [2:0] ST_FULL  = 3'd3;
    localparam logic [2:0] ST_EMPTY = 3'd4;
    localparam logic [2:0] ST_QERR  = 3'd5;

    typedef enum logic [1:0] {IDLE, EXEC, CHECK, RESP} state_t;

    state_t                  state, state_nx;
    logic [1:0]              op;
    logic [ID_WIDTH-1:0]     id;
    logic [PAYLOAD_SIZE-1:0] payload;
    logic [DEPTH-1:0]        live;
    logic [PTR_WIDTH-1:0]    slot_mem [DEPTH];
    logic [PTR_WIDTH-1:0]    tail;
    logic [2:0]              exec_status;
    logic                    hit;
    logic                    q_err;

    assign hit            = live[id];
    assign q_err          = q_error_reg | q_error_rem | q_error_time;
    assign cmd_ready      = (state == IDLE) && reset;
    assign rsp_valid      = (state == RESP);
    assign q_push_data    = {payload, id};
    assign q_remove_index = slot_mem[id];

    // Strobes are decoded from the state so an async reset cuts them at once.
    always_comb begin
        state_nx      = state;
        q_push_flag   = 1'b0;
        q_pop_flag    = 1'b0;
        q_remove_flag = 1'b0;
        exec_status   = ST_OK;
        unique case (state)
            IDLE:  if (cmd_valid) state_nx = EXEC;
            EXEC: begin
                state_nx = CHECK;
                unique case (op)
                    OP_ADD: begin
                        if (hit)         exec_status = ST_DUP;
                        else if (q_full) exec_status = ST_FULL;
                        else             q_push_flag = 1'b1;
                    end
                    OP_CANCEL: begin
                        if (!hit) exec_status   = ST_NF;
                        else      q_remove_flag = 1'b1;
                    end
                    OP_POP: begin
                        if (q_empty) exec_status = ST_EMPTY;
                        else         q_pop_flag  = 1'b1;
                    end
                    default: exec_status = ST_NF;
                endcase
            end
            CHECK: state_nx = RESP;
            RESP:  if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op          <= OP_ADD;
            id          <= '0;
            payload     <= '0;
            live        <= '0;
            tail        <= '0;
            rsp_status  <= ST_OK;
            rsp_id      <= '0;
            rsp_payload <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cmd_valid) begin
                op      <= cmd_op;
                id      <= cmd_id;
                payload <= cmd_payload;
            end
            if (state == EXEC) begin
                rsp_status <= exec_status;
                if (q_push_flag) begin
                    live[id] <= 1'b1;
                    tail     <= tail + 1'b1;
                end
                if (q_remove_flag) live[id] <= 1'b0;
                if (op == OP_POP) begin
                    rsp_id      <= q_pop_flag ? q_pop_data[ID_WIDTH-1:0] : '0;
                    rsp_payload <= q_pop_flag ? q_pop_data[QDATA_SIZE-1:ID_WIDTH] : '0;
                end else begin
                    rsp_id      <= id;
                    rsp_payload <= '0;
                end
            end
            // A popped ID is only released once the queue reports no error.
            if (state == CHECK) begin
                if (q_err)
                    rsp_status <= ST_QERR;
                else if (op == OP_POP && rsp_status == ST_OK)
                    live[rsp_id] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (q_push_flag) slot_mem[id] <= tail;
    end

endmodule

// File: tb/tb_queue_cmd_front.sv
// Directed bench for queue_cmd_front; the bench plays the queue.
// Uses a 4-entry queue so that fill and tail wrap are reachable.
module tb_queue_cmd_front;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_id = 8'd0;
    logic [23:0] cmd_payload = 24'd0;
    logic        q_push_flag;
    logic [31:0] q_push_data;
    logic        q_pop_flag;
    logic [31:0] q_pop_data = 32'd0;
    logic        q_remove_flag;
    logic [1:0]  q_remove_index;
    logic        q_full = 1'b0;
    logic        q_empty = 1'b1;
    logic        q_error_reg = 1'b0;
    logic        q_error_rem = 1'b0;
    logic        q_error_time = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [2:0]  rsp_status;
    logic [7:0]  rsp_id;
    logic [23:0] rsp_payload;

    queue_cmd_front #(
        .PAYLOAD_SIZE(24),
        .ID_WIDTH(8),
        .FIFO_SIZE(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_id(cmd_id),
        .cmd_payload(cmd_payload),
        .q_push_flag(q_push_flag),
        .q_push_data(q_push_data),
        .q_pop_flag(q_pop_flag),
        .q_pop_data(q_pop_data),
        .q_remove_flag(q_remove_flag),
        .q_remove_index(q_remove_index),
        .q_full(q_full),
        .q_empty(q_empty),
        .q_error_reg(q_error_reg),
        .q_error_rem(q_error_rem),
        .q_error_time(q_error_time),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_status(rsp_status),
        .rsp_id(rsp_id),
        .rsp_payload(rsp_payload)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] ADD = 2'd0, CANCEL = 2'd1, POP = 2'd2, RSV = 2'd3;
    localparam logic [2:0] OK = 3'd0, DUP = 3'd1, NF = 3'd2;
    localparam logic [2:0] FULL = 3'd3, EMPTY = 3'd4, QERR = 3'd5;

    int n_chk = 0;
    int n_pass = 0;

    logic [2:0]  e_strb;
    logic [1:0]  e_idx;
    logic [31:0] e_pdata;
    logic        stray;
    logic        r_valid;
    logic        r_done;
    logic        unstable;
    logic [2:0]  r_status;
    logic [7:0]  r_id;
    logic [23:0] r_pl;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One full command: offer, observe EXEC/CHECK, collect response.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] id,
                           input logic [23:0] pl, input logic err,
                           input int hold);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("ready_wait", {63'd0, cmd_ready}, 64'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_id = id;
        cmd_payload = pl;
        @(negedge clk);
        cmd_valid = 1'b0;
        e_strb  = {q_push_flag, q_pop_flag, q_remove_flag};
        e_idx   = q_remove_index;
        e_pdata = q_push_data;
        stray   = cmd_ready;
        @(negedge clk);
        stray = stray | q_push_flag | q_pop_flag | q_remove_flag;
        q_error_rem = err;
        @(negedge clk);
        q_error_rem = 1'b0;
        stray    = stray | q_push_flag | q_pop_flag | q_remove_flag;
        r_valid  = rsp_valid;
        r_status = rsp_status;
        r_id     = rsp_id;
        r_pl     = rsp_payload;
        unstable = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || cmd_ready || rsp_status !== r_status ||
                rsp_id !== r_id || rsp_payload !== r_pl)
                unstable = 1'b1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        r_done = !rsp_valid;
    endtask

    task automatic chk_rsp(input string tag, input logic [2:0] strb,
                           input logic [2:0] st);
        chk({tag, "_strb"}, {61'd0, e_strb}, {61'd0, strb});
        chk({tag, "_stat"}, {61'd0, r_status}, {61'd0, st});
        chk({tag, "_vld"}, {62'd0, r_valid, stray}, 64'd2);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_outs", {58'd0, rsp_valid, q_push_flag, q_pop_flag,
                         q_remove_flag, rsp_status == 3'd0, rsp_id == 8'd0},
            64'd3);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", {63'd0, cmd_ready}, 64'd1);

        run_cmd(ADD, 8'd5, 24'hABCDEF, 1'b0, 0);
        chk_rsp("add5", 3'b100, OK);
        chk("add5_data", {32'd0, e_pdata}, 64'hABCDEF05);
        chk("add5_rid", {32'd0, r_id, r_pl}, {32'd0, 8'd5, 24'd0});
        chk("add5_done", {63'd0, r_done}, 64'd1);

        run_cmd(ADD, 8'd5, 24'h123456, 1'b0, 0);
        chk_rsp("dup5", 3'b000, DUP);

        run_cmd(ADD, 8'd1, 24'h000001, 1'b0, 0);
        chk_rsp("add1", 3'b100, OK);
        run_cmd(ADD, 8'd2, 24'h000002, 1'b0, 0);
        chk_rsp("add2", 3'b100, OK);
        run_cmd(ADD, 8'd3, 24'h000003, 1'b0, 0);
        chk_rsp("add3", 3'b100, OK);

        run_cmd(CANCEL, 8'd2, 24'd0, 1'b0, 0);
        chk_rsp("can2", 3'b001, OK);
        chk("can2_idx", {62'd0, e_idx}, 64'd2);
        run_cmd(CANCEL, 8'd2, 24'd0, 1'b0, 0);
        chk_rsp("can2b", 3'b000, NF);

        q_full = 1'b1;
        q_empty = 1'b0;
        run_cmd(ADD, 8'd9, 24'h000009, 1'b0, 0);
        chk_rsp("full9", 3'b000, FULL);
        q_full = 1'b0;

        run_cmd(RSV, 8'd1, 24'd0, 1'b0, 0);
        chk_rsp("rsv1", 3'b000, NF);

        q_pop_data = 32'hABCDEF05;
        run_cmd(POP, 8'd77, 24'd0, 1'b0, 0);
        chk_rsp("pop5", 3'b010, OK);
        chk("pop5_rsp", {32'd0, r_id, r_pl}, {32'd0, 8'd5, 24'hABCDEF});

        run_cmd(ADD, 8'd5, 24'h000011, 1'b0, 0);
        chk_rsp("readd5", 3'b100, OK);
        chk("readd5_data", {32'd0, e_pdata}, 64'h00001105);
        run_cmd(CANCEL, 8'd5, 24'd0, 1'b0, 0);
        chk_rsp("can5", 3'b001, OK);
        chk("can5_wrap_idx", {62'd0, e_idx}, 64'd0);

        q_empty = 1'b1;
        run_cmd(POP, 8'd0, 24'd0, 1'b0, 0);
        chk_rsp("pop_empty", 3'b000, EMPTY);
        chk("pop_empty_pl", {40'd0, r_pl}, 64'd0);
        q_empty = 1'b0;

        run_cmd(CANCEL, 8'd1, 24'd0, 1'b1, 5);
        chk_rsp("can1_qerr", 3'b001, QERR);
        chk("can1_idx", {62'd0, e_idx}, 64'd1);
        chk("hold_stable", {63'd0, unstable}, 64'd0);
        chk("hold_done", {63'd0, r_done}, 64'd1);

        q_pop_data = 32'h00002203;
        run_cmd(POP, 8'd0, 24'd0, 1'b1, 0);
        chk_rsp("pop3_qerr", 3'b010, QERR);
        chk("pop3_rsp", {32'd0, r_id, r_pl}, {32'd0, 8'd3, 24'h000022});
        run_cmd(ADD, 8'd3, 24'h000033, 1'b0, 0);
        chk_rsp("add3_still", 3'b000, DUP);

        // Reset while an ADD sits in EXEC.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = ADD;
        cmd_id = 8'd20;
        cmd_payload = 24'h000020;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rx_pre_push", {63'd0, q_push_flag}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("rx_cut", {61'd0, q_push_flag, rsp_valid, cmd_ready}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_cmd(ADD, 8'd20, 24'h000020, 1'b0, 0);
        chk_rsp("rx_add20", 3'b100, OK);
        run_cmd(ADD, 8'd3, 24'h000033, 1'b0, 0);
        chk_rsp("rx_add3", 3'b100, OK);
        run_cmd(CANCEL, 8'd3, 24'd0, 1'b0, 0);
        chk_rsp("rx_can3", 3'b001, OK);
        chk("rx_can3_idx", {62'd0, e_idx}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
